// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and
// one-cycle overflow/underflow pulses. Define SYNC_FIFO_FWFT_EN for first-word fall-through.
module sync_fifo_flags #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_LEVEL   = 12,
  parameter int unsigned AE_LEVEL   = 4
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  W_inc,
  input  logic [DATA_WIDTH-1:0] W_Data,
  input  logic                  R_inc,
  output logic [DATA_WIDTH-1:0] R_Data,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Almost_Full,
  output logic                  Almost_Empty,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int unsigned PtrW  = ADDR_WIDTH + 1;
  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam logic [PtrW-1:0] AfLevel = PtrW'(AF_LEVEL);
  localparam logic [PtrW-1:0] AeLevel = PtrW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [PtrW-1:0]       w_ptr_q, r_ptr_q;
  logic                  overflow_q, underflow_q;
  logic                  wr_en, rd_en;
  logic [ADDR_WIDTH-1:0] w_addr, r_addr;

  assign w_addr = w_ptr_q[ADDR_WIDTH-1:0];
  assign r_addr = r_ptr_q[ADDR_WIDTH-1:0];

  // Flags depend only on the registered pointers, never on this cycle's requests.
  assign Count        = w_ptr_q - r_ptr_q;
  assign Full         = (w_addr == r_addr) && (w_ptr_q[ADDR_WIDTH] != r_ptr_q[ADDR_WIDTH]);
  assign Empty        = (w_ptr_q == r_ptr_q);
  assign Almost_Full  = (Count >= AfLevel);
  assign Almost_Empty = (Count <= AeLevel);
  assign Overflow     = overflow_q;
  assign Underflow    = underflow_q;

  assign wr_en = W_inc && !Full;
  assign rd_en = R_inc && !Empty;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en) w_ptr_q <= w_ptr_q + 1'b1;
      if (rd_en) r_ptr_q <= r_ptr_q + 1'b1;
      overflow_q  <= W_inc && Full;
      underflow_q <= R_inc && Empty;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[w_addr] <= W_Data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign R_Data = mem[r_addr];
`else
  logic [DATA_WIDTH-1:0] r_data_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_data_q <= '0;
    end else if (rd_en) begin
      r_data_q <= mem[r_addr];
    end
  end

  assign R_Data = r_data_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomised scoreboard bench for sync_fifo_flags (standard read mode), plus a small
// second instance with ADDR_WIDTH=2, DATA_WIDTH=32, AF_LEVEL=3, AE_LEVEL=1.
module tb_sync_fifo_flags;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       W_inc = 1'b0, R_inc = 1'b0;
  logic [7:0] W_Data = '0;
  logic [7:0] R_Data;
  logic       Full, Empty, Almost_Full, Almost_Empty, Overflow, Underflow;
  logic [4:0] Count;

  logic        w2 = 1'b0, r2 = 1'b0;
  logic [31:0] d2 = '0;
  logic [31:0] q2;
  logic        full2, empty2, af2, ae2, ovf2, udf2;
  logic [2:0]  count2;

  always #5 CLK = ~CLK;

  sync_fifo_flags dut (
    .CLK(CLK), .rst_n(rst_n), .W_inc(W_inc), .W_Data(W_Data), .R_inc(R_inc),
    .R_Data(R_Data), .Full(Full), .Empty(Empty), .Almost_Full(Almost_Full),
    .Almost_Empty(Almost_Empty), .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
  );

  sync_fifo_flags #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut2 (
    .CLK(CLK), .rst_n(rst_n), .W_inc(w2), .W_Data(d2), .R_inc(r2),
    .R_Data(q2), .Full(full2), .Empty(empty2), .Almost_Full(af2),
    .Almost_Empty(ae2), .Count(count2), .Overflow(ovf2), .Underflow(udf2)
  );

  typedef struct {
    int count;
    bit ovf;
    bit udf;
  } stat_t;

  int         vectors = 0;
  int         miscompares = 0;
  bit         checking = 1'b0;
  stat_t      stat_q[$];
  logic [7:0] data_q[$];
  logic [7:0] model_q[$];
  logic [31:0] model2_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive one cycle of requests, record what the reference
  // FIFO expects after the next rising edge, then wait for the following falling edge.
  task automatic step(input bit w, input logic [7:0] d, input bit r);
    stat_t s;
    int    n;
    W_inc  = w;
    W_Data = d;
    R_inc  = r;
    n      = model_q.size();
    s.ovf  = w && (n == DEPTH);
    s.udf  = r && (n == 0);
    if (r && n > 0) data_q.push_back(model_q.pop_front());
    if (w && n < DEPTH) model_q.push_back(d);
    s.count = model_q.size();
    stat_q.push_back(s);
    @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " Count"}, 64'(Count), 0);
    check({tag, " Empty"}, 64'(Empty), 1);
    check({tag, " Almost_Empty"}, 64'(Almost_Empty), 1);
    check({tag, " Full"}, 64'(Full), 0);
    check({tag, " Almost_Full"}, 64'(Almost_Full), 0);
    check({tag, " Overflow"}, 64'(Overflow), 0);
    check({tag, " Underflow"}, 64'(Underflow), 0);
    check({tag, " R_Data"}, 64'(R_Data), 0);
  endtask

  // Monitor: one status entry per checked edge; read data whenever the DUT accepts a pop.
  always @(posedge CLK) begin : monitor
    stat_t s;
    bit    acc;
    if (checking) begin
      acc = R_inc && !Empty;
      #1;
      if (stat_q.size() == 0) begin
        check("status queue underrun", 64'(1), 0);
      end else begin
        s = stat_q.pop_front();
        check("Count", 64'(Count), 64'(s.count));
        check("Full", 64'(Full), 64'(s.count == DEPTH));
        check("Empty", 64'(Empty), 64'(s.count == 0));
        check("Almost_Full", 64'(Almost_Full), 64'(s.count >= AF));
        check("Almost_Empty", 64'(Almost_Empty), 64'(s.count <= AE));
        check("Overflow", 64'(Overflow), 64'(s.ovf));
        check("Underflow", 64'(Underflow), 64'(s.udf));
      end
      if (acc) begin
        if (data_q.size() == 0) check("unexpected read accept", 64'(1), 0);
        else check("R_Data", 64'(R_Data), 64'(data_q.pop_front()));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int n2;
    bit acc2;
    logic [31:0] exp2;

    #12;
    check_reset_outputs("reset");
    @(negedge CLK);
    rst_n    = 1'b1;
    checking = 1'b1;

    // Fill past full, then one idle cycle to prove the overflow pulse is single-cycle.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Drain past empty.
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Simultaneous requests at full and at empty.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h5A, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Steady state at occupancy 5 across pointer wraps.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h85 + i), 1'b1);
    while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1);

    // Random traffic: write-biased then read-biased.
    for (int i = 0; i < 300; i++) begin
      if (i < 150) step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) == 0);
      else step(($urandom % 3) == 0, 8'($urandom), ($urandom % 4) != 0);
    end

    // Asynchronous reset with 7 words stored.
    while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    checking = 1'b0;
    W_inc = 1'b0;
    R_inc = 1'b0;
    check("Count before reset", 64'(Count), 7);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    model_q.delete();
    data_q.delete();
    stat_q.delete();
    @(negedge CLK);
    rst_n    = 1'b1;
    checking = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    checking = 1'b0;
    check("read data left unconsumed", 64'(data_q.size()), 0);

    // Small-geometry instance with its own queue reference.
    for (int i = 0; i < 200; i++) begin
      w2   = ($urandom % 2) == 1;
      r2   = ($urandom % 2) == 1;
      d2   = $urandom;
      n2   = model2_q.size();
      acc2 = r2 && n2 > 0;
      exp2 = acc2 ? model2_q.pop_front() : 32'h0;
      if (w2 && n2 < 4) model2_q.push_back(d2);
      @(posedge CLK);
      #1;
      n2 = model2_q.size();
      check("p2 Count", 64'(count2), 64'(n2));
      check("p2 Full", 64'(full2), 64'(n2 == 4));
      check("p2 Almost_Full", 64'(af2), 64'(n2 >= 3));
      check("p2 Almost_Empty", 64'(ae2), 64'(n2 <= 1));
      check("p2 Empty", 64'(empty2), 64'(n2 == 0));
      if (acc2) check("p2 R_Data", 64'(q2), 64'(exp2));
      @(negedge CLK);
    end
    w2 = 1'b0;
    r2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
